// File: rtl/md_sched.sv
// Purpose: sequences MIPS mult/div ops from E and owns the HI/LO registers.
// Latency: MULT/MULTU take MULT_CYCLES and DIV/DIVU take DIV_CYCLES busy cycles; MTHI/MTLO write in one edge.
// Backpressure: stall_md holds the pipeline while a D-stage MDU instruction would see an in-flight result.
module md_sched #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  input  logic        md_use_D,
  output logic        stall_md,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  localparam logic [3:0] MULT_N = 4'(MULT_CYCLES);
  localparam logic [3:0] DIV_N  = 4'(DIV_CYCLES);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] res_q, res_d;
  logic        skip_q, skip_d;   // divide by zero: run the full latency but leave HI/LO alone
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;

  logic        is_md_op;
  logic        is_mul;
  logic        signed_div;
  logic        b_zero;
  logic [63:0] prod_s;
  logic [63:0] prod_u;
  logic [31:0] a_mag;
  logic [31:0] b_mag;
  logic [31:0] den;
  logic [31:0] q_mag;
  logic [31:0] r_mag;
  logic [31:0] quot;
  logic [31:0] rem;
  logic [63:0] div_res;

  // Op decode shared by the FSM and the stall request
  always_comb begin
    is_md_op   = (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    is_mul     = (op == OP_MULT) || (op == OP_MULTU);
    signed_div = (op == OP_DIV);
    b_zero     = (b == 32'd0);
  end

  // Full 64-bit results computed from the E operands; latched only on the start edge
  always_comb begin
    prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u = {32'd0, a} * {32'd0, b};
    // Signed divide via magnitudes so the most-negative dividend needs no special case
    a_mag  = (signed_div && a[31]) ? (~a + 32'd1) : a;
    b_mag  = (signed_div && b[31]) ? (~b + 32'd1) : b;
    den    = b_zero ? 32'd1 : b_mag;
    q_mag  = a_mag / den;
    r_mag  = a_mag % den;
    quot   = (signed_div && (a[31] ^ b[31])) ? (~q_mag + 32'd1) : q_mag;
    rem    = (signed_div && a[31]) ? (~r_mag + 32'd1) : r_mag;
    div_res = {rem, quot};
  end

  // Next-state logic: start/flush/countdown/commit and MTHI/MTLO writes
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    res_d   = res_q;
    skip_d  = skip_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        // flush cancels whatever E is trying to issue this cycle
        if (start && !flush) begin
          if (is_md_op) begin
            state_d = RUN;
            if (is_mul) begin
              cnt_d  = MULT_N;
              res_d  = (op == OP_MULT) ? prod_s : prod_u;
              skip_d = 1'b0;
            end else begin
              cnt_d  = DIV_N;
              res_d  = div_res;
              skip_d = b_zero;
            end
          end else if (op == OP_MTHI) begin
            hi_d = a;
          end else if (op == OP_MTLO) begin
            lo_d = a;
          end
        end
      end
      RUN: begin
        // A new start while running is ignored; flush beats commit on the last cycle
        if (flush) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
        end else if (cnt_q == 4'd1) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          if (!skip_q) begin
            hi_d = res_q[63:32];
            lo_d = res_q[31:0];
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // State, counter, result latch and HI/LO registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      res_q   <= 64'd0;
      skip_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      res_q   <= res_d;
      skip_q  <= skip_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // Outputs: stall covers the issue cycle combinationally and then the whole busy window
  always_comb begin
    busy     = (state_q == RUN);
    stall_md = md_use_D & (busy | (start & is_md_op));
    hi       = hi_q;
    lo       = lo_q;
  end

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: scoreboard of expected {hi,lo} per issued op, popped when busy falls.
// Also covers MTHI/MTLO, flush, divide by zero, stall behaviour and mid-run reset.
module tb_md_sched;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic        clk;
  logic        reset_n;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        md_use_D;
  logic        stall_md;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_q[$];
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  md_sched #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset_n), .start(start), .op(op), .a(a), .b(b),
    .flush(flush), .md_use_D(md_use_D), .stall_md(stall_md), .busy(busy),
    .hi(hi), .lo(lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model of one op's effect on {hi,lo}
  function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] x,
                                        input logic [31:0] y, input logic [63:0] cur);
    longint          sx, sy;
    longint unsigned ux, uy;
    int              qs, rs;
    logic [63:0]     r;
    r = cur;
    case (o)
      3'd1: begin sx = longint'($signed(x)); sy = longint'($signed(y)); r = 64'(sx * sy); end
      3'd2: begin ux = {32'd0, x}; uy = {32'd0, y}; r = ux * uy; end
      3'd3: if (y != 0) begin qs = $signed(x) / $signed(y); rs = $signed(x) % $signed(y); r = {rs, qs}; end
      3'd4: if (y != 0) r = {x % y, x / y};
      default: r = cur;
    endcase
    return r;
  endfunction

  // Issue one mult/div op, then follow it to completion and score it
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic use_d);
    int n;
    logic [63:0] exp;
    @(negedge clk);
    start = 1'b1; op = o; a = x; b = y; md_use_D = use_d;
    #1;
    chk("stall_issue", {63'd0, stall_md}, {63'd0, use_d});
    exp = model(o, x, y, {m_hi, m_lo});
    sb_q.push_back(exp);
    {m_hi, m_lo} = exp;
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'd0;
    n = 0;
    while (busy && n < 40) begin
      chk("stall_busy", {63'd0, stall_md}, {63'd0, use_d});
      n++;
      @(posedge clk);
      #1;
    end
    chk("busy_len", 64'(n), 64'((o <= 3'd2) ? MULT_N : DIV_N));
    if (sb_q.size() > 0) chk("commit_hilo", {hi, lo}, sb_q.pop_front());
  endtask

  task automatic mt_op(input logic [2:0] o, input logic [31:0] x);
    @(negedge clk);
    start = 1'b1; op = o; a = x; md_use_D = 1'b1;
    #1;
    chk("mt_stall", {63'd0, stall_md}, 64'd0);
    @(posedge clk);
    #1;
    start = 1'b0; op = 3'd0;
    if (o == 3'd5) m_hi = x; else m_lo = x;
    chk("mt_busy", {63'd0, busy}, 64'd0);
    chk("mt_hilo", {hi, lo}, {m_hi, m_lo});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
    flush = 1'b0; md_use_D = 1'b1;
    #23;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_stall", {63'd0, stall_md}, 64'd0);
    reset_n = 1'b1;

    // Directed arithmetic
    run_op(3'd1, 32'hFFFFFFFD, 32'd5, 1'b1);
    chk("mult_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFF1);
    run_op(3'd4, 32'd17, 32'd5, 1'b0);
    chk("divu", {hi, lo}, {32'd2, 32'd3});
    run_op(3'd3, 32'hFFFFFFF9, 32'd2, 1'b1);
    chk("div_neg", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

    // MTHI/MTLO on consecutive cycles
    mt_op(3'd5, 32'h12345678);
    mt_op(3'd6, 32'h9);
    chk("mt_pair", {hi, lo}, {32'h12345678, 32'h9});

    mt_op(3'd5, 32'h11);
    mt_op(3'd6, 32'h22);
    run_op(3'd3, 32'd99, 32'd0, 1'b1);
    chk("div_zero", {hi, lo}, {32'h11, 32'h22});

    // MULT flushed while cnt==3
    @(negedge clk);
    start = 1'b1; op = 3'd1; a = 32'd7; b = 32'd6; md_use_D = 1'b1;
    @(posedge clk); #1; start = 1'b0; op = 3'd0;
    @(posedge clk);
    @(posedge clk); #1;
    chk("flush_pre_busy", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    chk("flush_stall", {63'd0, stall_md}, 64'd0);
    repeat (8) @(posedge clk);
    #1;
    chk("flush_hilo", {hi, lo}, {32'h11, 32'h22});

    run_op(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1);
    chk("multu_max", {hi, lo}, 64'hFFFFFFFE_00000001);

    // Random ops through the scoreboard
    for (int i = 0; i < 8; i++) begin
      logic [2:0]  ro;
      logic [31:0] ra, rb;
      ro = 3'($urandom_range(1, 4));
      ra = $urandom;
      rb = (i % 2 == 0) ? $urandom : 32'($urandom_range(1, 300));
      run_op(ro, ra, rb, 1'($urandom_range(0, 1)));
    end

    // Reset asserted mid-run
    mt_op(3'd5, 32'hAAAA);
    mt_op(3'd6, 32'h5555);
    @(negedge clk);
    start = 1'b1; op = 3'd2; a = 32'd3; b = 32'd4;
    @(posedge clk); #1; start = 1'b0; op = 3'd0;
    @(posedge clk); #1;
    chk("pre_rst_busy", {63'd0, busy}, 64'd1);
    @(negedge clk); #1;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_busy", {63'd0, busy}, 64'd0);
    chk("mid_rst_hilo", {hi, lo}, 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post_rst_busy", {63'd0, busy}, 64'd0);
    chk("post_rst_hilo", {hi, lo}, 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
